// File: rtl/mp_add_if.sv
// Operand/result streaming bundle for the multi-precision add/sub sequencer.
// The master drives operation control and operand words; the slave returns sum words and status.
interface mp_add_if #(
    parameter int NW_W = 4
);
    logic            start;
    logic            sub;
    logic [NW_W-1:0] nwords;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     a;
    logic [31:0]     b;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     sum;
    logic            out_last;
    logic            carry_out;
    logic            overflow;
    logic            busy;
    logic            done;

    modport master (
        output start, sub, nwords, in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, out_last, carry_out, overflow, busy, done
    );

    modport slave (
        input  start, sub, nwords, in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, out_last, carry_out, overflow, busy, done
    );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams 32-bit word pairs LSW first through one
// shared 32-bit carry-lookahead adder, chaining the carry between words in a register.

module cla_32_bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c0_i,
    output logic [31:0] s_o,
    output logic        c31_o,
    output logic        c30_o
);
    // 4-bit lookahead groups with the group carry rippling between groups
    always_comb begin
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] cv;
        logic        cg;
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        cv = 32'd0;
        cg = c0_i;
        for (int gi = 0; gi < 8; gi++) begin
            cv[gi*4]   = g[gi*4] | (p[gi*4] & cg);
            cv[gi*4+1] = g[gi*4+1] | (p[gi*4+1] & g[gi*4]) | (p[gi*4+1] & p[gi*4] & cg);
            cv[gi*4+2] = g[gi*4+2] | (p[gi*4+2] & g[gi*4+1])
                       | (p[gi*4+2] & p[gi*4+1] & g[gi*4])
                       | (p[gi*4+2] & p[gi*4+1] & p[gi*4] & cg);
            cv[gi*4+3] = g[gi*4+3] | (p[gi*4+3] & g[gi*4+2])
                       | (p[gi*4+3] & p[gi*4+2] & g[gi*4+1])
                       | (p[gi*4+3] & p[gi*4+2] & p[gi*4+1] & g[gi*4])
                       | (p[gi*4+3] & p[gi*4+2] & p[gi*4+1] & p[gi*4] & cg);
            cg = cv[gi*4+3];
        end
        s_o   = p ^ {cv[30:0], c0_i};
        c31_o = cv[31];
        c30_o = cv[30];
    end
endmodule

module mp_add_seq #(
    parameter int MAX_WORDS = 8,
    parameter int NW_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mp_add_if.slave     bus_if
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            sub_q, sub_d;
    logic [NW_W-1:0] nw_q, nw_d;
    logic [NW_W-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [31:0]     sum_q, sum_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            carry_out_q, carry_out_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;

    logic            in_ready_s;
    logic            accept_s;
    logic            out_hs_s;
    logic [NW_W-1:0] nw_sat_s;
    logic [31:0]     b_eff_s;
    logic [31:0]     add_s;
    logic            c31_s;
    logic            c30_s;

    assign b_eff_s = sub_q ? ~bus_if.b : bus_if.b;

    cla_32_bit u_cla (
        .a_i   (bus_if.a),
        .b_i   (b_eff_s),
        .c0_i  (carry_q),
        .s_o   (add_s),
        .c31_o (c31_s),
        .c30_o (c30_s)
    );

    // Single output register without skid buffer: accept only when the slot frees this cycle
    assign in_ready_s = (state_q == ST_RUN) & (~out_valid_q | bus_if.out_ready);
    assign accept_s   = bus_if.in_valid & in_ready_s;
    assign out_hs_s   = out_valid_q & bus_if.out_ready;
    assign nw_sat_s   = (bus_if.nwords > NW_W'(MAX_WORDS)) ? NW_W'(MAX_WORDS) : bus_if.nwords;

    // Next-state and output-register update logic
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        nw_d        = nw_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.start && (bus_if.nwords != '0)) begin
                    state_d     = ST_RUN;
                    sub_d       = bus_if.sub;
                    nw_d        = nw_sat_s;
                    carry_d     = bus_if.sub;
                    cnt_d       = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    sum_d       = add_s;
                    out_valid_d = 1'b1;
                    carry_d     = c31_s;
                    cnt_d       = cnt_q + NW_W'(1);
                    if (cnt_q == (nw_q - NW_W'(1))) begin
                        out_last_d  = 1'b1;
                        carry_out_d = c31_s;
                        overflow_d  = c31_s ^ c30_s;
                        state_d     = ST_DRAIN;
                    end else begin
                        out_last_d = 1'b0;
                    end
                end else if (out_hs_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_DRAIN: begin
                if (out_hs_s && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sub_q       <= 1'b0;
            nw_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            nw_q        <= nw_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign bus_if.in_ready  = in_ready_s;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.sum       = sum_q;
    assign bus_if.out_last  = out_last_q;
    assign bus_if.carry_out = carry_out_q;
    assign bus_if.overflow  = overflow_q;
    assign bus_if.busy      = (state_q != ST_IDLE);
    assign bus_if.done      = done_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: wide-arithmetic reference model plus literal pins.
module tb_mp_add_seq;
    typedef struct {
        logic [31:0] w;
        logic        last;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t e_cur;
    int   beats;
    logic [31:0] first_sum, last_sum;
    logic last_cout, last_ovf;
    logic hs_last_prev, stall_prev;
    logic [31:0] sum_prev;
    logic last_prev;

    mp_add_if #(.NW_W(4)) bus ();

    mp_add_seq #(.MAX_WORDS(8), .NW_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full-width two's complement add/sub of the n low words
    task automatic model_push(input logic s, input int n, input logic [255:0] av, input logic [255:0] bv);
        logic [256:0] one, mask, ae, be, full;
        logic sa, sb, sr;
        exp_t x;
        one  = 257'd1;
        mask = (one << (n * 32)) - one;
        ae   = {1'b0, av} & mask;
        be   = {1'b0, (s ? ~bv : bv)} & mask;
        full = ae + be + {256'd0, s};
        sa   = ae[n*32-1];
        sb   = be[n*32-1];
        sr   = full[n*32-1];
        for (int w = 0; w < n; w++) begin
            x.w    = full[w*32 +: 32];
            x.last = (w == n - 1);
            x.cout = full[n*32];
            x.ovf  = (sa == sb) && (sr != sa);
            exp_q.push_back(x);
        end
    endtask

    // Output compare, done pulse, hold-while-stalled and backpressure rules
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_last_prev = 1'b0;
            stall_prev   = 1'b0;
        end else begin
            if (hs_last_prev || bus.done)
                check("done_pulse", {63'd0, bus.done}, {63'd0, hs_last_prev});
            if (stall_prev) begin
                check("hold_sum", {32'd0, bus.sum}, {32'd0, sum_prev});
                check("hold_last", {63'd0, bus.out_last}, {63'd0, last_prev});
            end
            if (bus.out_valid && !bus.out_ready)
                check("no_accept_when_stalled", {63'd0, bus.in_ready}, 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got sum %0h expected no beat", bus.sum);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("sum_word", {32'd0, bus.sum}, {32'd0, e_cur.w});
                    check("out_last", {63'd0, bus.out_last}, {63'd0, e_cur.last});
                    if (e_cur.last) begin
                        check("carry_out", {63'd0, bus.carry_out}, {63'd0, e_cur.cout});
                        check("overflow", {63'd0, bus.overflow}, {63'd0, e_cur.ovf});
                    end
                end
                if (beats == 1) first_sum = bus.sum;
                last_sum  = bus.sum;
                last_cout = bus.carry_out;
                last_ovf  = bus.overflow;
            end
            hs_last_prev = bus.out_valid & bus.out_ready & bus.out_last;
            stall_prev   = bus.out_valid & ~bus.out_ready;
            sum_prev     = bus.sum;
            last_prev    = bus.out_last;
        end
    end

    task automatic run_op(input logic s, input int n_req, input logic [255:0] av, input logic [255:0] bv);
        int   n;
        int   guard;
        logic acc;
        logic [31:0] nreq_v;
        n      = (n_req > 8) ? 8 : n_req;
        nreq_v = n_req;
        beats  = 0;
        model_push(s, n, av, bv);
        bus.start  = 1'b1;
        bus.sub    = s;
        bus.nwords = nreq_v[3:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int w = 0; w < n; w++) begin
            bus.in_valid = 1'b1;
            bus.a = av[w*32 +: 32];
            bus.b = bv[w*32 +: 32];
            guard = 0;
            do begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 100);
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: got no accept of word %0d expected accept", w);
            end
        end
        bus.in_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((bus.busy || exp_q.size() != 0) && guard < 100);
        check("op_complete", {63'd0, bus.busy}, 64'd0);
        check("all_beats_seen", exp_q.size(), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.sub       = 1'b0;
        bus.nwords    = 4'd0;
        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b1;
        #2;
        check("reset_flags", {57'd0, bus.in_ready, bus.out_valid, bus.out_last, bus.carry_out,
                              bus.overflow, bus.busy, bus.done}, 64'd0);
        check("reset_sum", {32'd0, bus.sum}, 64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1-word add with carry out
        run_op(1'b0, 1, 256'hFFFFFFFF, 256'h1);
        check("t1_sum", {32'd0, last_sum}, 64'd0);
        check("t1_cout", {63'd0, last_cout}, 64'd1);
        check("t1_ovf", {63'd0, last_ovf}, 64'd0);

        // 2-word add, carry chained into word 1
        run_op(1'b0, 2, 256'h00000000_FFFFFFFF, 256'h00000000_00000001);
        check("t2_first", {32'd0, first_sum}, 64'd0);
        check("t2_last", {32'd0, last_sum}, 64'h1);
        check("t2_cout", {63'd0, last_cout}, 64'd0);
        check("t2_beats", beats, 64'd2);

        // Subtract with borrow
        run_op(1'b1, 1, 256'h0, 256'h1);
        check("t3_sum", {32'd0, last_sum}, 64'hFFFFFFFF);
        check("t3_cout", {63'd0, last_cout}, 64'd0);
        check("t3_ovf", {63'd0, last_ovf}, 64'd0);

        // Subtract with signed overflow
        run_op(1'b1, 1, 256'h80000000, 256'h1);
        check("t4_sum", {32'd0, last_sum}, 64'h7FFFFFFF);
        check("t4_cout", {63'd0, last_cout}, 64'd1);
        check("t4_ovf", {63'd0, last_ovf}, 64'd1);

        // nwords = 0 is ignored
        bus.start  = 1'b1;
        bus.nwords = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("nw0_busy", {63'd0, bus.busy}, 64'd0);
        check("nw0_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;

        // 3 words with output stall and a start pulse during RUN
        fork
            run_op(1'b0, 3, 256'h33333333_22222222_11111111, 256'h3_00000002_00000001);
            begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!bus.out_valid && guard < 100);
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                bus.start     = 1'b1;
                bus.sub       = 1'b1;
                bus.nwords    = 4'd5;
                @(posedge clk); #1;
                bus.start = 1'b0;
                bus.sub   = 1'b0;
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        check("t5_beats", beats, 64'd3);
        check("t5_first", {32'd0, first_sum}, 64'h11111112);
        check("t5_last", {32'd0, last_sum}, 64'h33333336);

        // nwords=12 saturates to 8 beats
        run_op(1'b0, 12, {256{1'b1}}, 256'h1);
        check("t6_beats", beats, 64'd8);
        check("t6_last", {32'd0, last_sum}, 64'd0);
        check("t6_cout", {63'd0, last_cout}, 64'd1);

        // Reset in the middle of a 4-word op
        beats = 0;
        model_push(1'b0, 4, 256'h4_00000003_00000002_00000001, 256'h1_00000001_00000001_00000001);
        bus.start  = 1'b1;
        bus.nwords = 4'd4;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 32'h1;
        bus.b        = 32'h1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (beats == 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t7_beat1", {32'd0, first_sum}, 64'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t7_reset_flags", {57'd0, bus.in_ready, bus.out_valid, bus.out_last, bus.carry_out,
                                 bus.overflow, bus.busy, bus.done}, 64'd0);
        check("t7_reset_sum", {32'd0, bus.sum}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t7_idle", {62'd0, bus.busy, bus.out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared cla_32_bit instance.
- Operates on operands of up to MAX_WORDS 32-bit words.
- Operand word pairs stream in least-significant word first over a valid/ready handshake. The block chains the carry between words in a register and streams sum words out over a second valid/ready handshake.
- Sits between the ALU issue logic and the adder datapath, giving 64/128/256-bit add/sub on the 32-bit CLA.

Parameters:
- MAX_WORDS, 8, maximum words per operation (2..15).
- NW_W, 4, width of nwords; must satisfy 2^NW_W > MAX_WORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A-B; latched at start.
- nwords  in  NW_W  word count; latched at start.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  operand word pair accepted when in_valid & in_ready.
- a  in  32  operand A word.
- b  in  32  operand B word.
- out_valid  out  1  sum word valid.
- out_ready  in  1  consumer accepts sum word.
- sum  out  32  sum word.
- out_last  out  1  marks the final sum word.
- carry_out  out  1  final carry out of bit 31 (for sub: 1 = no borrow). Valid with out_last.
- overflow  out  1  signed overflow of the full-width result. Valid with out_last.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse after the last word handshake.

Behaviour:
- Reset (async assert, synchronous release): state = IDLE. in_ready, out_valid, out_last, carry_out, overflow, busy, done all 0. sum = 0, carry register = 0, word counter = 0.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start with nwords != 0:
  - latch sub;
  - latch nwords, saturated to MAX_WORDS if larger;
  - carry register := sub;
  - counter := 0.
- start with nwords == 0 is ignored; the block stays in IDLE.
- start in RUN or DRAIN is ignored.
- Adder connections:
  - A = a;
  - B = sub ? ~b : b;
  - C0 = carry register.
  - Adder is purely combinational. The block adds no extra pipeline beyond the output register.
- in_ready = (state == RUN) & (!out_valid | out_ready). This is a single output register with no skid buffer.
- On input accept:
  - sum := adder S;
  - out_valid := 1;
  - carry register := adder C[31];
  - counter += 1.
  - If counter == nwords-1, additionally:
    - out_last := 1;
    - carry_out := C[31];
    - overflow := C[31] ^ C[30];
    - state := DRAIN.
- Latency: a word accepted at edge k appears on sum/out_valid after edge k. Throughput is 1 word per cycle while out_ready = 1.
- Output register holding: while out_valid & !out_ready, sum, out_last, carry_out and overflow hold stable.
- Output register clearing: out_valid clears on a handshake with no new input accepted in the same cycle. Simultaneous output handshake and input accept reloads the register.
- DRAIN -> IDLE on out_valid & out_ready & out_last. In that same cycle:
  - done pulses on the next edge;
  - out_last clears.
- carry_out and overflow hold until the next start is accepted.
- No input is accepted in DRAIN or IDLE.
- Reset mid-operation discards all state. In-flight words are lost and nothing is emitted after reset release.

Test Plan:
- nwords=1, sub=0, a=FFFFFFFF, b=00000001 -> one beat: sum=00000000, out_last=1, carry_out=1, overflow=0; done pulses one cycle after the handshake.
- nwords=2, sub=0, words (FFFFFFFF,00000001) then (00000000,00000000) -> sums 00000000 then 00000001, carry chained, out_last on beat 2, carry_out=0.
- nwords=1, sub=1, a=00000000, b=00000001 -> sum=FFFFFFFF, carry_out=0 (borrow), overflow=0.
- nwords=1, sub=1, a=80000000, b=00000001 -> sum=7FFFFFFF, overflow=1, carry_out=1.
- nwords=3 with out_ready held low 3 cycles after beat 1 -> in_ready=0 throughout; sum stays stable; all 3 words are delivered in order with no loss or duplication.
- Corner cases:
  - start with nwords=0 -> busy stays 0;
  - start asserted during RUN -> ignored;
  - nwords=12 with MAX_WORDS=8 -> exactly 8 beats;
  - rst_n low after beat 1 of 4 -> all outputs return to reset values immediately, and IDLE is reached.
